lsu_mem_ctrl: RTL
=================

Name: lsu_mem_ctrl

Overview:
Parametrised load/store stage for the RV32I core. It accepts one load or store per request from EX and routes it either to the QSPI memory port or to the memory-mapped IO port, selected by address tag. It handles byte, halfword and word accesses with lane steering, byte enables and sign/zero extension. It stalls the pipeline via dmrw_run until the access completes, then issues a registered one-cycle writeback to RFW.

Parameters:
XLEN, 32, data/address width (only 32 supported for lane logic; checked by generate-time assertion)
IO_TAG, 2'b11, value of adr[XLEN-1:XLEN-2] selecting IO space
IO_ADR_W, 14, IO word-address width; IO address = adr[IO_ADR_W+1:2]
IO_RD_LAT, 2, cycles from dma_io_radr_en to valid dma_io_rdata (1..7)
TO_W, 8, timeout counter width (used only with MEM_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cpu_stat_dmrw  in  1  sequencer permits MA-stage access this cycle
cmd_ld_ma  in  1  load request
cmd_st_ma  in  1  store request
ldst_code_ma  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
rd_adr_ma  in  5  load destination register
rd_data_ma  in  XLEN  effective address
st_data_ma  in  XLEN  store data, right-justified
dmrw_run  out  1  stall: access in progress
rd_adr_wb  out  5  writeback register
wbk_rd_reg_wb  out  1  writeback strobe
wbk_data_wb  out  XLEN  extended load data
d_read_req  out  1  QSPI read request pulse
d_read_adr  out  XLEN  word-aligned read address
read_valid  in  1  QSPI read data valid
read_data  in  XLEN  full aligned word
d_write_req  out  1  QSPI write request pulse
d_write_adr  out  XLEN  word-aligned write address
d_write_be  out  4  byte enables
d_write_data  out  XLEN  lane-replicated write data
write_finish  in  1  QSPI write done
dma_io_we  out  1  IO write strobe
dma_io_wadr  out  IO_ADR_W  IO write word address
dma_io_wdata  out  XLEN  IO write data
dma_io_radr_en  out  1  IO read strobe
dma_io_radr  out  IO_ADR_W  IO read word address
dma_io_rdata  in  XLEN  IO read data
misalign_err  out  1  one-cycle pulse: misaligned or illegal access dropped
bus_err  out  1  one-cycle pulse: timeout abort (0 when feature off)

Behaviour:
- Accept = state IDLE & cpu_stat_dmrw & (cmd_ld_ma|cmd_st_ma). If both cmds are high, load wins. On accept, latch address, rd_adr, code and store data.
- Misaligned: H with adr[0]=1, or W with adr[1:0]!=0. IO access with code other than W/010 is also illegal. On any of these: no request issued, misalign_err pulses the next cycle, no writeback, state stays IDLE.
- States: IDLE, MRD, MWR, IORD, IOWR.
  - IDLE -> MRD / MWR / IORD / IOWR on accept, selected by tag and ld/st.
  - MRD -> IDLE on read_valid.
  - MWR -> IDLE on write_finish.
  - IORD: counter loads IO_RD_LAT; -> IDLE when it reaches 1.
  - IOWR -> IDLE after 1 cycle.
- Requests: d_read_req, d_write_req, dma_io_we and dma_io_radr_en are single-cycle pulses, registered, asserted in the first cycle of the target state. Addresses and data are held stable for the whole state.
- Byte enables:
  - B: 4'b0001 << adr[1:0].
  - H: 4'b0011 << adr[1:0].
  - W: 4'b1111.
  - d_write_data replicates the byte or halfword across all lanes.
- Load extraction: select lane by latched adr[1:0]. B/H sign-extend; BU/HU zero-extend; W passes through.
- Writeback:
  - On the completing cycle (read_valid in MRD, last IORD cycle), register the extended data.
  - wbk_rd_reg_wb pulses high the next cycle together with rd_adr_wb.
  - Suppressed when rd_adr is 0.
  - Stores never write back.
- dmrw_run = accept | (state != IDLE). It is low in the writeback cycle.
- read_valid/write_finish arriving in IDLE or the wrong state are ignored.
- Reset: state IDLE, all pulses 0, wbk_data_wb 0, rd_adr_wb 0, counters 0. Reset mid-access abandons it; no writeback follows.

Optional Feature:
MEM_TIMEOUT_EN:
- When defined, a TO_W-bit counter clears on entry to MRD/MWR and increments each cycle.
- At all-ones without completion: return to IDLE, pulse bus_err, no writeback.
- When undefined, MRD/MWR wait indefinitely and bus_err is tied 0.

Test Plan:
1. LB at 0x0000_0103, read_data=0x80FF_1234 after 3 cycles -> d_read_adr=0x100; wbk_data_wb=0xFFFF_FF80 with wbk_rd_reg_wb one cycle after read_valid; dmrw_run high 4 cycles.
2. SH at 0x0000_0202, st_data=0x1234_ABCD -> d_write_be=4'b1100, d_write_data=0xABCD_ABCD; dmrw_run drops after write_finish; no writeback.
3. LW at 0xC000_0010, IO_RD_LAT=2, dma_io_rdata=0x5A5A_0001 -> dma_io_radr=14'h4 pulse; wbk_data_wb=0x5A5A_0001 on rd_adr 5.
4. LH at 0x0000_0001, then SB to 0xC000_0000 -> misalign_err pulses for each; no d_read_req, no dma_io_we, no writeback.
5. LHU to rd_adr 0 at 0x0000_0002, read_data=0x8001_0000 -> access completes; wbk_rd_reg_wb stays 0.
6. MEM_TIMEOUT_EN, TO_W=4, read_valid never returns -> bus_err after 15 cycles; return to IDLE; next LW completes normally. rst_n low mid-MRD -> state IDLE, no writeback.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store stage: routes MA-stage accesses to the QSPI memory port or the IO port,
// with lane steering and sign extension. Optional access timeout: MEM_TIMEOUT_EN.
module lsu_mem_ctrl #(
    parameter int         XLEN      = 32,
    parameter logic [1:0] IO_TAG    = 2'b11,
    parameter int         IO_ADR_W  = 14,
    parameter int         IO_RD_LAT = 2,
    parameter int         TO_W      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cpu_stat_dmrw,
    input  logic                cmd_ld_ma,
    input  logic                cmd_st_ma,
    input  logic [2:0]          ldst_code_ma,
    input  logic [4:0]          rd_adr_ma,
    input  logic [XLEN-1:0]     rd_data_ma,
    input  logic [XLEN-1:0]     st_data_ma,
    output logic                dmrw_run,
    output logic [4:0]          rd_adr_wb,
    output logic                wbk_rd_reg_wb,
    output logic [XLEN-1:0]     wbk_data_wb,
    output logic                d_read_req,
    output logic [XLEN-1:0]     d_read_adr,
    input  logic                read_valid,
    input  logic [XLEN-1:0]     read_data,
    output logic                d_write_req,
    output logic [XLEN-1:0]     d_write_adr,
    output logic [3:0]          d_write_be,
    output logic [XLEN-1:0]     d_write_data,
    input  logic                write_finish,
    output logic                dma_io_we,
    output logic [IO_ADR_W-1:0] dma_io_wadr,
    output logic [XLEN-1:0]     dma_io_wdata,
    output logic                dma_io_radr_en,
    output logic [IO_ADR_W-1:0] dma_io_radr,
    input  logic [XLEN-1:0]     dma_io_rdata,
    output logic                misalign_err,
    output logic                bus_err
);

    generate
        if (XLEN != 32) begin : g_xlen_chk
            $error("lsu_mem_ctrl: lane logic supports XLEN=32 only");
        end
        if (IO_RD_LAT < 1 || IO_RD_LAT > 7) begin : g_lat_chk
            $error("lsu_mem_ctrl: IO_RD_LAT must be 1..7");
        end
        if (TO_W < 2) begin : g_tow_chk
            $error("lsu_mem_ctrl: TO_W must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {S_IDLE, S_MRD, S_MWR, S_IORD, S_IOWR} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] adr_q, adr_d, sdat_q, sdat_d, wbk_data_q, wbk_data_d;
    logic [4:0]      rd_q, rd_d, rd_wb_q, rd_wb_d;
    logic [2:0]      code_q, code_d, io_cnt_q, io_cnt_d;
    logic            rd_req_q, rd_req_d, wr_req_q, wr_req_d;
    logic            io_we_q, io_we_d, io_re_q, io_re_d;
    logic            mis_q, mis_d, wbk_q, wbk_d;
    logic            accept, is_io, illegal, io_done, ld_done, to_hit;
    logic [XLEN-1:0] ld_raw, ld_shift, ld_ext;

    assign accept = (state_q == S_IDLE) & cpu_stat_dmrw & (cmd_ld_ma | cmd_st_ma);
    assign is_io  = (rd_data_ma[XLEN-1:XLEN-2] == IO_TAG);

    // Misaligned halfword/word, undefined funct3, or sub-word IO access
    always_comb begin
        illegal = 1'b0;
        case (ldst_code_ma)
            3'b000:  illegal = 1'b0;
            3'b001:  illegal = rd_data_ma[0];
            3'b010:  illegal = (rd_data_ma[1:0] != 2'b00);
            3'b100:  illegal = ~cmd_ld_ma;
            3'b101:  illegal = ~cmd_ld_ma | rd_data_ma[0];
            default: illegal = 1'b1;
        endcase
        if (is_io && ldst_code_ma != 3'b010) begin
            illegal = 1'b1;
        end
    end

    // The IO read counter is loaded in the strobe cycle, so data is taken IO_RD_LAT cycles later
    assign io_done = (state_q == S_IORD) & ~io_re_q & (io_cnt_q == 3'd1);
    assign ld_done = ((state_q == S_MRD) & read_valid) | io_done;

`ifdef MEM_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            berr_q;

    assign to_hit = (&to_cnt_q) &
                    (((state_q == S_MRD) & ~read_valid) | ((state_q == S_MWR) & ~write_finish));

    always_comb begin
        to_cnt_d = '0;
        if (state_q == S_MRD || state_q == S_MWR) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
            berr_q   <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            berr_q   <= to_hit;
        end
    end

    assign bus_err = berr_q;
`else
    assign to_hit  = 1'b0;
    assign bus_err = 1'b0;
`endif

    // State register and datapath flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            adr_q      <= '0;
            sdat_q     <= '0;
            wbk_data_q <= '0;
            rd_q       <= '0;
            rd_wb_q    <= '0;
            code_q     <= '0;
            io_cnt_q   <= '0;
            rd_req_q   <= 1'b0;
            wr_req_q   <= 1'b0;
            io_we_q    <= 1'b0;
            io_re_q    <= 1'b0;
            mis_q      <= 1'b0;
            wbk_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            adr_q      <= adr_d;
            sdat_q     <= sdat_d;
            wbk_data_q <= wbk_data_d;
            rd_q       <= rd_d;
            rd_wb_q    <= rd_wb_d;
            code_q     <= code_d;
            io_cnt_q   <= io_cnt_d;
            rd_req_q   <= rd_req_d;
            wr_req_q   <= wr_req_d;
            io_we_q    <= io_we_d;
            io_re_q    <= io_re_d;
            mis_q      <= mis_d;
            wbk_q      <= wbk_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && !illegal) begin
                    if (is_io) begin
                        state_d = cmd_ld_ma ? S_IORD : S_IOWR;
                    end else begin
                        state_d = cmd_ld_ma ? S_MRD : S_MWR;
                    end
                end
            end
            S_MRD:   if (read_valid || to_hit) state_d = S_IDLE;
            S_MWR:   if (write_finish || to_hit) state_d = S_IDLE;
            S_IORD:  if (io_done) state_d = S_IDLE;
            S_IOWR:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Load lane extraction from whichever port is completing
    always_comb begin
        ld_raw   = (state_q == S_IORD) ? dma_io_rdata : read_data;
        ld_shift = ld_raw >> {adr_q[1:0], 3'b000};
        case (code_q)
            3'b000:  ld_ext = {{(XLEN-8){ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_ext = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_ext = {{(XLEN-8){1'b0}}, ld_shift[7:0]};
            3'b101:  ld_ext = {{(XLEN-16){1'b0}}, ld_shift[15:0]};
            default: ld_ext = ld_raw;
        endcase
    end

    // Output / register-input logic
    always_comb begin
        adr_d      = adr_q;
        sdat_d     = sdat_q;
        rd_d       = rd_q;
        code_d     = code_q;
        io_cnt_d   = io_cnt_q;
        wbk_data_d = wbk_data_q;
        rd_wb_d    = rd_wb_q;
        rd_req_d   = 1'b0;
        wr_req_d   = 1'b0;
        io_we_d    = 1'b0;
        io_re_d    = 1'b0;
        wbk_d      = 1'b0;
        mis_d      = accept & illegal;
        if (accept) begin
            adr_d    = rd_data_ma;
            sdat_d   = st_data_ma;
            rd_d     = rd_adr_ma;
            code_d   = ldst_code_ma;
            rd_req_d = ~illegal & ~is_io & cmd_ld_ma;
            wr_req_d = ~illegal & ~is_io & ~cmd_ld_ma;
            io_re_d  = ~illegal & is_io & cmd_ld_ma;
            io_we_d  = ~illegal & is_io & ~cmd_ld_ma;
        end
        if (state_q == S_IORD) begin
            if (io_re_q) begin
                io_cnt_d = 3'(IO_RD_LAT);
            end else if (io_cnt_q == 3'd1) begin
                io_cnt_d = 3'd0;
            end else begin
                io_cnt_d = io_cnt_q - 3'd1;
            end
        end
        if (ld_done) begin
            wbk_data_d = ld_ext;
            rd_wb_d    = rd_q;
            wbk_d      = (rd_q != 5'd0);
        end
    end

    // Store lane steering from the latched request
    always_comb begin
        case (code_q[1:0])
            2'b00: begin
                d_write_be   = 4'b0001 << adr_q[1:0];
                d_write_data = {4{sdat_q[7:0]}};
            end
            2'b01: begin
                d_write_be   = 4'b0011 << adr_q[1:0];
                d_write_data = {2{sdat_q[15:0]}};
            end
            default: begin
                d_write_be   = 4'b1111;
                d_write_data = sdat_q;
            end
        endcase
    end

    assign dmrw_run       = accept | (state_q != S_IDLE);
    assign d_read_req     = rd_req_q;
    assign d_read_adr     = {adr_q[XLEN-1:2], 2'b00};
    assign d_write_req    = wr_req_q;
    assign d_write_adr    = {adr_q[XLEN-1:2], 2'b00};
    assign dma_io_we      = io_we_q;
    assign dma_io_wadr    = adr_q[IO_ADR_W+1:2];
    assign dma_io_wdata   = sdat_q;
    assign dma_io_radr_en = io_re_q;
    assign dma_io_radr    = adr_q[IO_ADR_W+1:2];
    assign misalign_err   = mis_q;
    assign wbk_rd_reg_wb  = wbk_q;
    assign rd_adr_wb      = rd_wb_q;
    assign wbk_data_wb    = wbk_data_q;

endmodule
